// File: rtl/ysyx_24090012_csr_seq.sv
// CSR write-port sequencer: turns one CSRRx/ECALL/MRET/NOP into a series of CSR file writes.
// Optional feature macro: YSYX_CSR_SEQ_MSTATUS_EN (enables the mstatus update on ECALL/MRET).
module ysyx_24090012_csr_seq #(
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_pc,
    input  logic [11:0] req_csr_addr,
    input  logic [31:0] req_src,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_redirect,
    output logic [31:0] resp_npc,
    output logic        csr_valid,
    input  logic        csr_ready,
    output logic        csr_wen,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_EPC    = 3'd1;
    localparam logic [2:0] S_WR_CAUSE  = 3'd2;
    localparam logic [2:0] S_WR_STATUS = 3'd3;
    localparam logic [2:0] S_WR_CSR    = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    logic [2:0]  state_reg, state_next;
    logic [2:0]  op_reg;
    logic [31:0] pc_reg;
    logic [11:0] addr_reg;
    logic [31:0] src_reg;
    logic [31:0] rdata_reg;
    logic        redirect_reg;
    logic [31:0] npc_reg;

    logic        accept;
    logic        csr_hs;
    logic        enter_resp;
    logic [2:0]  entry_op;
    logic [31:0] status_ecall;
    logic [31:0] status_mret;

    assign req_ready     = (state_reg == S_IDLE);
    assign accept        = req_valid && req_ready;
    assign csr_hs        = csr_valid && csr_ready;
    assign resp_valid    = (state_reg == S_RESP);
    assign resp_rdata    = rdata_reg;
    assign resp_redirect = redirect_reg;
    assign resp_npc      = npc_reg;

    // NOP and (macro-off) MRET enter RESP straight from IDLE, before op_reg is loaded.
    assign entry_op   = (state_reg == S_IDLE) ? req_op : op_reg;
    assign enter_resp = (state_reg != S_RESP) && (state_next == S_RESP);

    always_comb begin
        status_ecall        = mstatus_i;
        status_ecall[7]     = mstatus_i[3];
        status_ecall[3]     = 1'b0;
        status_ecall[12:11] = 2'b11;
        status_mret         = mstatus_i;
        status_mret[3]      = mstatus_i[7];
        status_mret[7]      = 1'b1;
        status_mret[12:11]  = 2'b11;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: state_next = S_WR_CSR;
                        OP_ECALL: state_next = S_WR_EPC;
`ifdef YSYX_CSR_SEQ_MSTATUS_EN
                        OP_MRET:  state_next = S_WR_STATUS;
`else
                        OP_MRET:  state_next = S_RESP;
`endif
                        default:  state_next = S_RESP;
                    endcase
                end
            end
            S_WR_EPC:    if (csr_hs) state_next = S_WR_CAUSE;
`ifdef YSYX_CSR_SEQ_MSTATUS_EN
            S_WR_CAUSE:  if (csr_hs) state_next = S_WR_STATUS;
`else
            S_WR_CAUSE:  if (csr_hs) state_next = S_RESP;
`endif
            S_WR_STATUS: if (csr_hs) state_next = S_RESP;
            S_WR_CSR:    if (csr_hs) state_next = S_RESP;
            S_RESP:      if (resp_ready) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Write-port drive is purely a function of state, so it holds steady until the handshake.
    always_comb begin
        csr_valid = 1'b0;
        csr_wen   = 1'b0;
        csr_addr  = 12'h000;
        csr_wdata = 32'h0;
        case (state_reg)
            S_WR_EPC: begin
                csr_valid = 1'b1;
                csr_wen   = 1'b1;
                csr_addr  = 12'h341;
                csr_wdata = pc_reg;
            end
            S_WR_CAUSE: begin
                csr_valid = 1'b1;
                csr_wen   = 1'b1;
                csr_addr  = 12'h342;
                csr_wdata = ECALL_CAUSE;
            end
            S_WR_STATUS: begin
                csr_valid = 1'b1;
                csr_wen   = 1'b1;
                csr_addr  = 12'h300;
                csr_wdata = (op_reg == OP_ECALL) ? status_ecall : status_mret;
            end
            S_WR_CSR: begin
                csr_valid = 1'b1;
                csr_addr  = addr_reg;
                case (op_reg)
                    OP_CSRRS: begin
                        csr_wen   = (src_reg != 32'h0);
                        csr_wdata = csr_rdata | src_reg;
                    end
                    OP_CSRRC: begin
                        csr_wen   = (src_reg != 32'h0);
                        csr_wdata = csr_rdata & ~src_reg;
                    end
                    default: begin
                        csr_wen   = 1'b1;
                        csr_wdata = src_reg;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            op_reg       <= 3'd0;
            pc_reg       <= 32'h0;
            addr_reg     <= 12'h000;
            src_reg      <= 32'h0;
            rdata_reg    <= 32'h0;
            redirect_reg <= 1'b0;
            npc_reg      <= 32'h0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg       <= req_op;
                pc_reg       <= req_pc;
                addr_reg     <= req_csr_addr;
                src_reg      <= req_src;
                rdata_reg    <= 32'h0;
                redirect_reg <= 1'b0;
                npc_reg      <= 32'h0;
            end
            if ((state_reg == S_WR_CSR) && csr_hs) begin
                rdata_reg <= csr_rdata;
            end
            if (enter_resp) begin
                redirect_reg <= (entry_op == OP_ECALL) || (entry_op == OP_MRET);
                if (entry_op == OP_ECALL) begin
                    npc_reg <= mtvec_i & ~32'h3;
                end else if (entry_op == OP_MRET) begin
                    npc_reg <= mepc_i;
                end else begin
                    npc_reg <= 32'h0;
                end
            end
        end
    end

endmodule
